// File: rtl/sdram_responder.sv
// sdram_responder: device-side model of a 16-bit SDR SDRAM for the picosoc
// controller. Decodes CS/RAS/CAS/WE, tracks per-bank open rows, CAS latency,
// auto-precharge and refresh, serves reads/writes from a small synchronous
// store and flags protocol violations on err_cmd.
module sdram_responder #(
  parameter int unsigned MEM_AW   = 12,
  parameter int unsigned CL_RESET = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sd_cs,
  input  logic        sd_ras,
  input  logic        sd_cas,
  input  logic        sd_we,
  input  logic [1:0]  sd_ba,
  input  logic [12:0] sd_addr,
  input  logic [1:0]  sd_dqm,
  input  logic [15:0] sd_dq_in,
  output logic [15:0] sd_dq_out,
  output logic        sd_dq_oe,
  output logic        err_cmd,
  output logic [2:0]  cas_latency,
  output logic [15:0] refresh_count
);

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 13;
  localparam int unsigned CW    = 9;
  localparam int unsigned BW    = 2;
  localparam int unsigned BANKS = 4;
  localparam int unsigned IDX_W = BW + AW + CW;
  localparam int unsigned DEPTH = 2 ** MEM_AW;

  // RAS/CAS/WE opcodes, valid only while sd_cs is low
  localparam logic [2:0] OP_ACTIVE = 3'b011;
  localparam logic [2:0] OP_READ   = 3'b101;
  localparam logic [2:0] OP_WRITE  = 3'b100;
  localparam logic [2:0] OP_PRECH  = 3'b010;
  localparam logic [2:0] OP_REFR   = 3'b001;
  localparam logic [2:0] OP_LMODE  = 3'b000;

  logic [2:0]          op;
  logic [BANKS-1:0]    open_q, open_d;
  logic [AW-1:0]       row_q [BANKS];
  logic [AW-1:0]       row_d [BANKS];
  logic [2:0]          cl_q, cl_d;
  logic [15:0]         rc_q, rc_d;
  logic                err_q, err_d;
  logic [1:0]          st_vld_q, st_vld_d;
  logic [DW-1:0]       st_dat_q [2];
  logic [DW-1:0]       st_dat_d [2];
  logic [DW-1:0]       dout_q, dout_d;
  logic                oe_q, oe_d;
  logic                wr_en;
  logic [IDX_W-1:0]    idx_full;
  logic [MEM_AW-1:0]   mem_idx;
  logic [DW-1:0]       rd_data;
  logic [DW-1:0]       mem [DEPTH];

  assign op = {sd_ras, sd_cas, sd_we};

  // Word address: {bank, open row of that bank, column}, truncated to the store
  always_comb begin
    idx_full = {sd_ba, row_q[sd_ba], sd_addr[CW-1:0]};
    mem_idx  = MEM_AW'(idx_full);
    rd_data  = mem[mem_idx];
  end

  // Backing store write port with per-lane masks; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (!sd_dqm[0]) mem[mem_idx][7:0]  <= sd_dq_in[7:0];
      if (!sd_dqm[1]) mem[mem_idx][15:8] <= sd_dq_in[15:8];
    end
  end

  // Command decode, bank bookkeeping, read pipeline advance and error detection
  always_comb begin
    open_d      = open_q;
    row_d       = row_q;
    cl_d        = cl_q;
    rc_d        = rc_q;
    err_d       = 1'b0;
    wr_en       = 1'b0;
    // Stage 1 moves to stage 0; stage 0 is consumed into the output register
    st_vld_d    = {1'b0, st_vld_q[1]};
    st_dat_d[0] = st_dat_q[1];
    st_dat_d[1] = st_dat_q[1];
    oe_d        = st_vld_q[0];
    dout_d      = st_vld_q[0] ? st_dat_q[0] : '0;

    if (!sd_cs) begin
      case (op)
        OP_ACTIVE: begin
          if (open_q[sd_ba]) begin
            err_d = 1'b1;
          end else begin
            open_d[sd_ba] = 1'b1;
            row_d[sd_ba]  = sd_addr;
          end
        end
        OP_WRITE: begin
          if (!open_q[sd_ba]) begin
            err_d = 1'b1;
          end else begin
            wr_en = 1'b1;
            // Controller driving data while we still drive the bus
            if (oe_q) err_d = 1'b1;
            if (sd_addr[10]) open_d[sd_ba] = 1'b0;
          end
        end
        OP_READ: begin
          if (!open_q[sd_ba]) begin
            err_d = 1'b1;
          end else begin
            // Entry slot chosen so data reaches the pins CL-1 edges later
            if (cl_q == 3'd2) begin
              st_vld_d[0] = 1'b1;
              st_dat_d[0] = rd_data;
            end else begin
              st_vld_d[1] = 1'b1;
              st_dat_d[1] = rd_data;
            end
            if (sd_addr[10]) open_d[sd_ba] = 1'b0;
          end
        end
        OP_PRECH: begin
          if (sd_addr[10]) open_d = '0;
          else             open_d[sd_ba] = 1'b0;
        end
        OP_REFR: begin
          if (|open_q) err_d = 1'b1;
          else         rc_d  = rc_q + 16'd1;
        end
        OP_LMODE: begin
          if ((|open_q) || !((sd_addr[6:4] == 3'd2) || (sd_addr[6:4] == 3'd3)) ||
              (sd_addr[2:0] != 3'd0)) begin
            err_d = 1'b1;
          end else begin
            cl_d = sd_addr[6:4];
          end
        end
        default: ; // NOP, BURST_TERM
      endcase
    end
  end

  // State and output registers; reset closes banks and flushes pending reads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      open_q   <= '0;
      for (int i = 0; i < BANKS; i++) row_q[i] <= '0;
      cl_q     <= 3'(CL_RESET);
      rc_q     <= '0;
      err_q    <= 1'b0;
      st_vld_q <= '0;
      st_dat_q[0] <= '0;
      st_dat_q[1] <= '0;
      dout_q   <= '0;
      oe_q     <= 1'b0;
    end else begin
      open_q   <= open_d;
      for (int i = 0; i < BANKS; i++) row_q[i] <= row_d[i];
      cl_q     <= cl_d;
      rc_q     <= rc_d;
      err_q    <= err_d;
      st_vld_q <= st_vld_d;
      st_dat_q[0] <= st_dat_d[0];
      st_dat_q[1] <= st_dat_d[1];
      dout_q   <= dout_d;
      oe_q     <= oe_d;
    end
  end

  assign sd_dq_out     = dout_q;
  assign sd_dq_oe      = oe_q;
  assign err_cmd       = err_q;
  assign cas_latency   = cl_q;
  assign refresh_count = rc_q;

endmodule
